// File: rtl/wavelet_coef_quantizer.sv
// Reads one frame of wavelet coefficients from RAM, applies a dead-zone shift quantizer and
// streams sign-magnitude symbols through a 2-entry FIFO. Optional macro: QUANT_NZ_COUNT_EN.
module wavelet_coef_quantizer #(
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = 4096,
  parameter int Q_SHIFT   = 4,
  parameter int OUT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_rden,
  input  logic [15:0]       ram_q,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef QUANT_NZ_COUNT_EN
  ,
  output logic [ADDR_W:0]   nz_count
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [16:0]       QMAX      = 17'((1 << (OUT_W - 1)) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [OUT_W:0]    mem_q [2];
  logic [OUT_W:0]    mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef QUANT_NZ_COUNT_EN
  logic [ADDR_W:0]   nz_q, nz_d;
`endif

  logic [16:0]       ext, mag, q_raw;
  logic [OUT_W-2:0]  q_sat;
  logic [OUT_W-1:0]  sym;
  logic [1:0]        occ_after_pop;
  logic              pop, issue;

  always_comb begin
    ext   = {ram_q[15], ram_q};
    mag   = ram_q[15] ? (~ext + 17'd1) : ext;
    q_raw = mag >> Q_SHIFT;
    q_sat = (q_raw > QMAX) ? QMAX[OUT_W-2:0] : q_raw[OUT_W-2:0];
    sym   = {ram_q[15] & (q_raw != 17'd0), q_sat};
  end

  assign out_valid   = (count_q != 2'd0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
  assign out_last    = out_valid & mem_q[rd_ptr_q][OUT_W];
  assign ram_rd_addr = addr_q;
  assign ram_rden    = issue;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef QUANT_NZ_COUNT_EN
  assign nz_count    = nz_q;
`endif

  // A read may issue only if the FIFO slot it will land in is free after this cycle's pop.
  always_comb begin
    pop           = out_valid & out_ready;
    occ_after_pop = count_q - 2'(pop);
    issue         = (state_q == READ) && ((3'(occ_after_pop) + 3'(inflight_q)) < 3'd2);

    state_d         = state_q;
    addr_d          = addr_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (addr_q == LAST_ADDR);
    mem_d[0]        = mem_q[0];
    mem_d[1]        = mem_q[1];
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q + 2'(inflight_q) - 2'(pop);
`ifdef QUANT_NZ_COUNT_EN
    nz_d            = nz_q;
`endif

    if (inflight_q) begin
      mem_d[wr_ptr_q] = {inflight_last_q, sym};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
`ifdef QUANT_NZ_COUNT_EN
      if (out_data[OUT_W-2:0] != '0) nz_d = nz_q + 1'b1;
`endif
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          busy_d  = 1'b1;
`ifdef QUANT_NZ_COUNT_EN
          nz_d    = '0;
`endif
        end
      end
      READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef QUANT_NZ_COUNT_EN
      nz_q            <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      mem_q           <= mem_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef QUANT_NZ_COUNT_EN
      nz_q            <= nz_d;
`endif
    end
  end

endmodule

// File: tb/tb_wavelet_coef_quantizer.sv
// Self-checking bench for wavelet_coef_quantizer: RAM model, behavioural quantizer model and a
// per-cycle monitor. Covers the QUANT_NZ_COUNT_EN build as well when that macro is defined.
module tb_wavelet_coef_quantizer;

  localparam int AW = 12;
  localparam int NW = 4096;
  localparam int QS = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rden;
  logic [15:0]   ram_q = '0;
  logic [OW-1:0] out_data;
  logic          out_valid, out_last, busy, done;
`ifdef QUANT_NZ_COUNT_EN
  logic [AW:0]   nz_count;
`endif

  wavelet_coef_quantizer #(.ADDR_W(AW), .NUM_WORDS(NW), .Q_SHIFT(QS), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_rd_addr(ram_rd_addr), .ram_rden(ram_rden), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef QUANT_NZ_COUNT_EN
    , .nz_count(nz_count)
`endif
  );

  always #5 clk = ~clk;

  logic signed [15:0] ram [NW];
  int exp_sym [NW];
  int cap [NW];
  int total = 0, bad = 0, cyc = 0;
  int exp_idx = 0, issued = 0, dones = 0, exp_nz = 0;
  int first_valid_cyc = -1, last_acc_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic chk_en = 1'b0, prev_stall = 1'b0, mon_accept;
  logic [OW:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data appears on ram_q the cycle after ram_rden.
  always @(posedge clk) if (ram_rden) ram_q <= ram[ram_rd_addr];

  function automatic int quant(input int v);
    int m, q;
    m = (v < 0) ? -v : v;
    q = m >> QS;
    if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
    return ((v < 0 && q != 0) ? (1 << (OW - 1)) : 0) + q;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_addr"},  ram_rd_addr, 0);
    checkOutput({tag, "_rden"},  ram_rden, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_last"},  out_last, 0);
    checkOutput({tag, "_data"},  out_data, 0);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_done"},  done, 0);
  endtask

  // mode 0: ramp, 1: random with quantizer corners, 2: zeros with ten words of 100
  task automatic loadRam(input int mode);
    for (int i = 0; i < NW; i++) begin
      case (mode)
        0:       ram[i] = 16'(i);
        1:       ram[i] = 16'($urandom());
        default: ram[i] = 16'sd0;
      endcase
    end
    if (mode == 1) begin
      ram[0] = -16'sd15;
      ram[1] = -16'sd16;
      ram[2] = 16'sh7FFF;
      ram[3] = 16'sh8000;
      ram[4] = 16'sd2032;
    end
    if (mode == 2) for (int k = 0; k < 10; k++) ram[k * 397 + 3] = 16'sd100;
    exp_nz = 0;
    for (int i = 0; i < NW; i++) begin
      exp_sym[i] = quant(int'(ram[i]));
      if ((exp_sym[i] % (1 << (OW - 1))) != 0) exp_nz++;
    end
  endtask

  function automatic logic pickReady(input int duty);
    return (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
  endfunction

  // Per-cycle monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else if (chk_en) begin
      mon_accept = out_valid && out_ready;
      if (out_valid) begin
        if (exp_idx >= NW) checkOutput("extra_symbol", exp_idx, NW - 1);
        else begin
          checkOutput("out_data", out_data, exp_sym[exp_idx]);
          checkOutput("out_last", out_last, (exp_idx == NW - 1) ? 1 : 0);
        end
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) checkOutput("stall_hold", {out_last, out_data}, prev_word);
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      if (ram_rden) begin
        checkOutput("rd_addr", ram_rd_addr, issued);
        checkOutput("rd_window", ((issued - exp_idx - (mon_accept ? 1 : 0)) <= 1) ? 1 : 0, 1);
        issued++;
      end
      if (mon_accept) begin
        if (exp_idx < NW) cap[exp_idx] = out_data;
        exp_idx++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        checkOutput("done_after_last", exp_idx, NW);
        checkOutput("done_busy_low", busy, 0);
`ifdef QUANT_NZ_COUNT_EN
        checkOutput("nz_at_done", nz_count, exp_nz);
`endif
        dones++;
        done_cyc = cyc;
      end
    end
  end

  // Runs one frame: start pulse, optional second start at restart_at, random out_ready duty.
  task automatic applyStimulus(input int duty, input int restart_at);
    int d0, n;
    exp_idx = 0; issued = 0; first_valid_cyc = -1; prev_stall = 1'b0; d0 = dones;
    @(posedge clk); #2;
    start = 1'b1; start_cyc = cyc; out_ready = pickReady(duty);
    n = 0;
    while (dones == d0 && n < 60000) begin
      @(posedge clk); #2;
      start = (restart_at > 0 && n == restart_at);
      out_ready = pickReady(duty);
      if (n == 0) begin
        checkOutput("busy_after_start", busy, 1);
`ifdef QUANT_NZ_COUNT_EN
        checkOutput("nz_cleared", nz_count, 0);
`endif
      end
      n++;
    end
    if (dones == d0) checkOutput("done_timeout", dones - d0, 1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("one_done", dones - d0, 1);
    checkOutput("symbol_count", exp_idx, NW);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_valid", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset in the middle of a frame once address 100 is reached.
    loadRam(0);
    exp_idx = 0; issued = 0; prev_stall = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int n = 0; n < 500 && ram_rd_addr != 100; n++) begin
      @(posedge clk); #2;
    end
    checkOutput("reach_addr100", ram_rd_addr, 100);
    rst = 1'b1; prev_stall = 1'b0;
    #1;
    checkIdleZero("midreset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_no_done", done, 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;

`ifdef QUANT_NZ_COUNT_EN
    loadRam(2);
    applyStimulus(100, 0);
    checkOutput("nz_hold_ten", nz_count, 10);
`endif

    // Ramp frame at full rate with an ignored second start.
    loadRam(0);
    applyStimulus(100, 50);
    checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 3);
    checkOutput("back_to_back", last_acc_cyc - first_valid_cyc, NW - 1);
    checkOutput("done_delay", done_cyc - last_acc_cyc, 1);
    checkOutput("ramp_sym0",    cap[0], 8'h00);
    checkOutput("ramp_sym15",   cap[15], 8'h00);
    checkOutput("ramp_sym16",   cap[16], 8'h01);
    checkOutput("ramp_sym100",  cap[100], 8'h06);
    checkOutput("ramp_sym4095", cap[4095], 8'h7F);

    // Random data with quantizer corners under 30% out_ready backpressure.
    loadRam(1);
    applyStimulus(30, 0);
    checkOutput("corner_m15",    cap[0], 8'h00);
    checkOutput("corner_m16",    cap[1], 8'h81);
    checkOutput("corner_7fff",   cap[2], 8'h7F);
    checkOutput("corner_m32768", cap[3], 8'hFF);
    checkOutput("corner_2032",   cap[4], 8'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
